// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package imem_arb_pkg;

    // State encoding doubles as the owner output.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } arb_state_t;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_NONE = 2'b00;
    localparam owner_t OWN_I    = 2'b01;
    localparam owner_t OWN_D    = 2'b10;

endpackage

// File: rtl/imem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie, favour the port that did not win last.
import imem_arb_pkg::*;

module rr_pick2 (
    input  logic   reqi,
    input  logic   reqd,
    input  owner_t last_grant,
    output owner_t grant
);

    always_comb begin
        grant = OWN_NONE;
        if (reqi && reqd)
            grant = (last_grant == OWN_I) ? OWN_D : OWN_I;
        else if (reqi)
            grant = OWN_I;
        else if (reqd)
            grant = OWN_D;
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one memory port between fetch (I) and data/loader (D) with
// round-robin arbitration, grant held until the memory handshake completes.
import imem_arb_pkg::*;

module imem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iren,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              iflush,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    input  logic              dren,
    input  logic              dwen,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_store,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_load,
    output logic [1:0]        owner
);

    arb_state_t        state, state_n;
    logic              drop, drop_n;
    owner_t            last_grant, grant;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_store;
    logic              lat_wen;

    rr_pick2 u_pick (
        .reqi       (iren & ~iflush),
        .reqd       (dren | dwen),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            drop       <= 1'b0;
            last_grant <= OWN_D;
            lat_addr   <= '0;
            lat_store  <= '0;
            lat_wen    <= 1'b0;
        end else begin
            state <= state_n;
            drop  <= drop_n;
            if (state == IDLE && grant != OWN_NONE) begin
                last_grant <= grant;
                lat_addr   <= (grant == OWN_D) ? daddr : iaddr;
                lat_store  <= (grant == OWN_D) ? dstore : '0;
                // a simultaneous read+write request is serviced as a write
                lat_wen    <= (grant == OWN_D) && dwen;
            end
        end
    end

    always_comb begin
        state_n = state;
        drop_n  = drop;
        case (state)
            IDLE: begin
                drop_n = 1'b0;
                if (grant == OWN_I)
                    state_n = BUSY_I;
                else if (grant == OWN_D)
                    state_n = BUSY_D;
            end
            BUSY_I: begin
                // fetch abandoned (flush or request withdrawn): finish the
                // memory access but swallow its hit
                if (iflush || !iren)
                    drop_n = 1'b1;
                if (mem_ready) begin
                    state_n = IDLE;
                    drop_n  = 1'b0;
                end
            end
            BUSY_D: begin
                if (mem_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ihit      = 1'b0;
        iload     = '0;
        dhit      = 1'b0;
        dload     = '0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_store = '0;
        case (state)
            BUSY_I: begin
                mem_ren  = 1'b1;
                mem_addr = lat_addr;
                ihit     = mem_ready && !drop && !iflush && iren;
                iload    = ihit ? mem_load : '0;
            end
            BUSY_D: begin
                mem_wen   = lat_wen;
                mem_ren   = !lat_wen;
                mem_addr  = lat_addr;
                mem_store = lat_store;
                dhit      = mem_ready;
                dload     = mem_ready ? mem_load : '0;
            end
            default: ;
        endcase
    end

    assign owner = state;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: per-cycle vector table plus hand sequences.
module tb_imem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iren, iflush, dren, dwen, mem_ready;
    logic [31:0] iaddr, daddr, dstore, mem_load;
    logic        ihit, dhit, mem_ren, mem_wen;
    logic [31:0] iload, dload, mem_addr, mem_store;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    imem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .iren(iren), .iaddr(iaddr), .iflush(iflush), .ihit(ihit), .iload(iload),
        .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_store(mem_store), .mem_ready(mem_ready), .mem_load(mem_load),
        .owner(owner)
    );

    typedef struct {
        logic        rst, iren, iflush, dren, dwen, rdy;
        logic [31:0] iaddr, daddr, dstore, mload;
        logic        e_ihit, e_dhit, e_ren, e_wen;
        logic [1:0]  e_own;
        logic [31:0] e_addr, e_store, e_iload, e_dload;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, iren, iflush, dren, dwen, rdy,
        input logic [31:0] ia, da, ds, ml,
        input logic eih, edh, eren, ewen, input logic [1:0] eown,
        input logic [31:0] ea, es, eil, edl);
        vec_t v;
        v.rst = rst; v.iren = iren; v.iflush = iflush; v.dren = dren; v.dwen = dwen;
        v.rdy = rdy; v.iaddr = ia; v.daddr = da; v.dstore = ds; v.mload = ml;
        v.e_ihit = eih; v.e_dhit = edh; v.e_ren = eren; v.e_wen = ewen; v.e_own = eown;
        v.e_addr = ea; v.e_store = es; v.e_iload = eil; v.e_dload = edl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, ir, ifl, dr, dw, rdy,
                         input logic [31:0] ia, da, ds, ml);
        RST = rst; iren = ir; iflush = ifl; dren = dr; dwen = dw; mem_ready = rdy;
        iaddr = ia; daddr = da; dstore = ds; mem_load = ml;
    endtask

    initial begin
        int  hits;
        logic prev_d, first;

        // columns: rst iren iflush dren dwen rdy | iaddr daddr dstore mload |
        //          ihit dhit ren wen own | addr store iload dload
        // single fetch straight after reset
        tbl.push_back(mk(0,1,0,0,0,1, 'h40,0,0,'hDEADBEEF, 0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,1, 'h40,0,0,'hDEADBEEF, 1,0,1,0,1, 'h40,0,'hDEADBEEF,0));
        tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,'hDEADBEEF,    0,0,0,0,0, 0,0,0,0));
        // re-reset, then tie: I, D, I
        tbl.push_back(mk(1,1,0,1,0,1, 'h10,'h20,0,'h55, 0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,0,1,0,1, 'h10,'h20,0,'h55, 0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,0,1,0,1, 'h10,'h20,0,'h55, 1,0,1,0,1, 'h10,0,'h55,0));
        tbl.push_back(mk(0,1,0,1,0,1, 'h10,'h20,0,'h55, 0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,0,1,0,1, 'h10,'h20,0,'h55, 0,1,1,0,2, 'h20,0,0,'h55));
        tbl.push_back(mk(0,1,0,1,0,1, 'h10,'h20,0,'h55, 0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,0,1,0,1, 'h10,'h20,0,'h55, 1,0,1,0,1, 'h10,0,'h55,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,          0,0,0,0,0, 0,0,0,0));
        // write with slow memory
        tbl.push_back(mk(0,0,0,0,1,0, 0,'h100,'h1234,0,       0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,0, 0,'h100,'h1234,0,       0,0,0,1,2, 'h100,'h1234,0,0));
        tbl.push_back(mk(0,0,0,0,1,0, 0,'h100,'h1234,0,       0,0,0,1,2, 'h100,'h1234,0,0));
        tbl.push_back(mk(0,0,0,0,1,1, 0,'h100,'h1234,'hAAAA,  0,1,0,1,2, 'h100,'h1234,0,'hAAAA));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,                0,0,0,0,0, 0,0,0,0));
        // flush in second busy cycle, then a fresh fetch hits
        tbl.push_back(mk(0,1,0,0,0,0, 'h80,0,0,0,    0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0, 'h80,0,0,0,    0,0,1,0,1, 'h80,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0, 'h80,0,0,0,    0,0,1,0,1, 'h80,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 'h80,0,0,0,    0,0,1,0,1, 'h80,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1, 'h80,0,0,'h77, 0,0,1,0,1, 'h80,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0, 'h200,0,0,0,   0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,1, 'h200,0,0,'h99,1,0,1,0,1, 'h200,0,'h99,0));
        // flush coincident with ready; pending dren wins next IDLE
        tbl.push_back(mk(0,1,0,0,0,0, 'h300,0,0,0,       0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,0,1,0,0, 'h300,'h400,0,0,   0,0,1,0,1, 'h300,0,0,0));
        tbl.push_back(mk(0,1,1,1,0,1, 'h300,'h400,0,'h11,0,0,1,0,1, 'h300,0,0,0));
        tbl.push_back(mk(0,0,0,1,0,0, 0,'h400,0,0,       0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,1,0,1, 0,'h400,0,'h22,    0,1,1,0,2, 'h400,0,0,'h22));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,           0,0,0,0,0, 0,0,0,0));
        // read+write means write; request dropped mid-access still completes
        tbl.push_back(mk(0,0,0,1,1,0, 0,'h500,'hCAFE,0,    0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,'h500,'hCAFE,0,    0,0,0,1,2, 'h500,'hCAFE,0,0));
        tbl.push_back(mk(0,0,0,0,0,1, 0,'h500,'hCAFE,'h33, 0,1,0,1,2, 'h500,'hCAFE,0,'h33));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,             0,0,0,0,0, 0,0,0,0));

        drive(1,0,0,0,0,0, 0,0,0,0);
        @(negedge CLK);

        foreach (tbl[i]) begin
            @(negedge CLK);
            drive(tbl[i].rst, tbl[i].iren, tbl[i].iflush, tbl[i].dren, tbl[i].dwen,
                  tbl[i].rdy, tbl[i].iaddr, tbl[i].daddr, tbl[i].dstore, tbl[i].mload);
            #1;
            chk($sformatf("r%0d.ihit", i),  {31'b0, ihit},    {31'b0, tbl[i].e_ihit});
            chk($sformatf("r%0d.dhit", i),  {31'b0, dhit},    {31'b0, tbl[i].e_dhit});
            chk($sformatf("r%0d.ren", i),   {31'b0, mem_ren}, {31'b0, tbl[i].e_ren});
            chk($sformatf("r%0d.wen", i),   {31'b0, mem_wen}, {31'b0, tbl[i].e_wen});
            chk($sformatf("r%0d.owner", i), {30'b0, owner},   {30'b0, tbl[i].e_own});
            chk($sformatf("r%0d.addr", i),  mem_addr,  tbl[i].e_addr);
            chk($sformatf("r%0d.store", i), mem_store, tbl[i].e_store);
            chk($sformatf("r%0d.iload", i), iload,     tbl[i].e_iload);
            chk($sformatf("r%0d.dload", i), dload,     tbl[i].e_dload);
        end

        // reset during BUSY_D abandons it; following tie goes to I
        @(negedge CLK); drive(0,0,0,1,0,0, 0,'h600,0,0);
        #1 chk("rstmid.idle_own", {30'b0, owner}, 32'd0);
        @(negedge CLK); #1;
        chk("rstmid.busy_own", {30'b0, owner}, 32'd2);
        chk("rstmid.busy_ren", {31'b0, mem_ren}, 32'd1);
        @(negedge CLK); drive(1,0,0,1,0,0, 0,'h600,0,0);
        @(negedge CLK); drive(0,1,0,1,0,1, 'h700,'h600,0,'h5A);
        #1;
        chk("rstmid.own",  {30'b0, owner}, 32'd0);
        chk("rstmid.ren",  {31'b0, mem_ren}, 32'd0);
        chk("rstmid.wen",  {31'b0, mem_wen}, 32'd0);
        chk("rstmid.dhit", {31'b0, dhit}, 32'd0);
        @(negedge CLK); #1;
        chk("rstmid.tie_own",  {30'b0, owner}, 32'd1);
        chk("rstmid.tie_ihit", {31'b0, ihit}, 32'd1);
        chk("rstmid.tie_addr", mem_addr, 32'h700);
        chk("rstmid.iload",    iload, 32'h5A);

        // continuous contention: hits alternate, starting with D
        hits = 0; prev_d = 1'b0; first = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK); #1;
            chk($sformatf("starve%0d.strobes", c), {31'b0, mem_ren & mem_wen}, 32'd0);
            chk($sformatf("starve%0d.hits", c),    {31'b0, ihit & dhit}, 32'd0);
            if (ihit || dhit) begin
                chk($sformatf("starve%0d.alt", c), {31'b0, dhit}, {31'b0, ~prev_d});
                prev_d = dhit;
                hits++;
                first = 1'b0;
            end
        end
        chk("starve.count", hits, 32'd8);
        chk("starve.any", {31'b0, first}, 32'd0);

        // iren withdrawn mid-fetch acts as a flush
        @(negedge CLK); drive(0,0,0,0,0,1, 0,0,0,0);
        @(negedge CLK); drive(0,1,0,0,0,0, 'h900,0,0,0);
        #1 chk("idrop.idle", {30'b0, owner}, 32'd0);
        @(negedge CLK); drive(0,0,0,0,0,0, 'h900,0,0,0);
        #1 chk("idrop.busy", {30'b0, owner}, 32'd1);
        @(negedge CLK); drive(0,1,0,0,0,1, 'h900,0,0,'h1);
        #1;
        chk("idrop.ihit", {31'b0, ihit}, 32'd0);
        chk("idrop.ren",  {31'b0, mem_ren}, 32'd1);
        @(negedge CLK); drive(0,0,0,0,0,0, 0,0,0,0);
        #1 chk("idrop.back", {30'b0, owner}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares one single-ported instruction/unified memory port between two requesters: the fetch stage (read-only, port I) and a data/loader port (read/write, port D).
- Sits between the fetch stage and the memory controller.
- Generates the ihit that fetch uses to advance its PC.
- Uses round-robin arbitration, holds each grant until the memory handshake completes, and supports fetch flush on misprediction.

Parameters:
- ADDR_W, 32, address width for all ports.
- DATA_W, 32, data width for all ports.

Ports:
- CLK  in  1  clock, rising-edge.
- RST  in  1  reset, synchronous, active-high.
- iren  in  1  fetch read request; held until ihit or iflush.
- iaddr  in  ADDR_W  fetch address.
- iflush  in  1  fetch misprediction flush; abandons the fetch request.
- ihit  out  1  fetch read complete, 1-cycle pulse.
- iload  out  DATA_W  fetch read data, valid when ihit.
- dren  in  1  data read request; held until dhit.
- dwen  in  1  data write request; held until dhit.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dhit  out  1  data access complete, 1-cycle pulse.
- dload  out  DATA_W  data read data, valid when dhit with a read.
- mem_ren  out  1  memory read strobe.
- mem_wen  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_store  out  DATA_W  memory write data.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_load  in  DATA_W  memory read data, valid with mem_ready.
- owner  out  2  current owner: 00 none, 01 I, 10 D.

Behaviour:
- **Reset.** RST sampled high at a rising edge gives:
  - state IDLE, drop=0, last_grant=D;
  - all outputs 0 in the following cycle.
  - Reset mid-transaction abandons the transaction with no hit pulse. The memory side must tolerate the strobe dropping.
- **States.** IDLE, BUSY_I, BUSY_D; owner encodes the state.
- **IDLE.**
  - mem_ren=mem_wen=0.
  - Candidates are reqI = iren & ~iflush and reqD = dren | dwen.
  - Only reqI: go to BUSY_I. Only reqD: go to BUSY_D.
  - Both: grant the port not equal to last_grant, so the first tie after reset goes to I.
  - On grant, latch addr/store/rw into registers and update last_grant.
- **BUSY_I.**
  - mem_ren=1, mem_addr = latched iaddr.
  - iflush in this state sets drop=1.
  - On mem_ready: ihit = ~drop & ~iflush, iload = mem_load (combinational, same cycle). Then go to IDLE and clear drop.
- **BUSY_D.**
  - mem_wen = latched dwen, mem_ren = ~latched dwen.
  - mem_addr/mem_store come from the latched values.
  - On mem_ready: dhit=1, dload = mem_load; go to IDLE.
  - dren and dwen both high: treated as a write.
- **Latency.** Request seen in IDLE at edge N → strobes asserted in cycle N+1. Earliest hit is cycle N+1, if mem_ready is already high. One IDLE bubble follows every completion, so throughput is at most one access per 2 cycles.
- **Handshake.** Requesters hold address, data and request stable until hit. A dropped dren/dwen mid-BUSY_D is ignored; the access completes and dhit still pulses.
- **Fetch request edge cases.**
  - iren dropping mid-BUSY_I without iflush: treated as a flush, drop=1.
  - iflush and mem_ready in the same cycle: ihit suppressed.
  - iflush in IDLE: I is not a candidate that cycle.
- **Invariants.**
  - mem_ren and mem_wen are never both 1.
  - ihit and dhit are never both 1.
  - A hit only occurs with mem_ready in the matching BUSY state.
  - No starvation: with both requesting continuously, grants alternate I, D, I, D.

Decomposition:
- Package imem_arb_pkg:
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D};
  - owner_t 2-bit encoding constants OWN_NONE/OWN_I/OWN_D.
- Sub-module rr_pick2: a combinational 2-way round-robin picker taking (reqI, reqD, last_grant) and producing grant. Everything else stays in imem_arbiter.

Test Plan:
- **Reset then single fetch.** RST 1 cycle, then iren=1, iaddr=0x40, mem_ready=1 from cycle 2 → mem_ren=1/mem_addr=0x40 in cycle 2; ihit=1 with iload=mem_load (0xDEADBEEF) in cycle 2; owner back to 00 in cycle 3.
- **Tie after reset.** iren and dren both held, mem_ready always 1 → grant order I, D, I, D; ihit/dhit alternate every 2 cycles, never coincident.
- **Write.** dwen=1, daddr=0x100, dstore=0x1234, mem_ready delayed 3 cycles → mem_wen=1 and mem_ren=0 for 3 cycles; dhit is a single pulse on the ready cycle; mem_store=0x1234 throughout.
- **Flush mid-fetch.** iren at 0x80, mem_ready delayed 4 cycles, iflush pulse in the 2nd busy cycle → no ihit; arbiter returns to IDLE after mem_ready; a new iren at 0x200 is then granted and hits.
- **Flush/ready coincidence.** iflush and mem_ready in the same cycle → ihit=0; a pending dren is granted next IDLE.
- **Reset mid-transaction.** RST during BUSY_D → the next cycle has owner=00, all strobes 0 and no dhit; then a tie grants I first.
